window_issue_sequencer: RTL
===========================

Name: window_issue_sequencer

Overview:
- Walks convolution window centres across a frame of configurable width and height, with separate X and Y strides.
- Hands each centre to one allocator slot per valid/ready handshake, in batches of up to NUM_ALLOC.
- At the end of each batch, reports the padded-coordinate bounding box of the pixels that batch covers, so the fetch stage can load exactly that region.
- Sits between the layer controller (start, batch_req) and the allocator array / pixel fetch unit.

Parameters:
- NUM_ALLOC, 220, allocator slots per batch (>=1).
- COORD_W, 8, coordinate and image-dimension width.
- PAD_W, 2, padding (kernel radius) width.
- STRIDE_W, 3, stride width.
- IDX_W, $clog2(NUM_ALLOC), allocator index width (minimum 1).
- CNT_W, $clog2(NUM_ALLOC+1), batch count width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a frame; accepted only in IDLE or DONE.
- img_w  in  COORD_W  frame width (pixels).
- img_h  in  COORD_W  frame height (pixels).
- padding  in  PAD_W  border / kernel radius.
- stride_x  in  STRIDE_W  horizontal step.
- stride_y  in  STRIDE_W  vertical step.
- batch_req  in  1  request next batch; accepted only in WAIT_BATCH.
- issue_valid  out  1  centre presented.
- issue_ready  in  1  allocator accepts centre.
- center_x  out  COORD_W  centre X, padded coords.
- center_y  out  COORD_W  centre Y, padded coords.
- alloc_idx  out  IDX_W  target slot for current issue.
- batch_valid  out  1  one-cycle pulse: box and count valid.
- batch_count  out  CNT_W  issues in completed batch.
- box_x_min  out  COORD_W  bounding box of batch, padded coords.
- box_x_max  out  COORD_W  bounding box of batch, padded coords.
- box_y_min  out  COORD_W  bounding box of batch, padded coords.
- box_y_max  out  COORD_W  bounding box of batch, padded coords.
- busy  out  1  high in WAIT_BATCH and ISSUE.
- done  out  1  frame complete; held until start or rst.

Behaviour:
- Reset values: every output is 0; state is IDLE.
- rst mid-operation aborts the frame immediately; no batch_valid is emitted.
- Configuration is latched on an accepted start. Input changes afterwards are ignored until the next start.

State machine:
- IDLE / DONE + start, with degenerate config (img_w==0, img_h==0, stride_x==0 or stride_y==0) -> DONE.
  - done=1 on the next cycle.
  - issue_valid never asserts.
- IDLE / DONE + start, otherwise -> WAIT_BATCH.
  - center <= (padding, padding), done <= 0.
- WAIT_BATCH + batch_req -> ISSUE.
  - alloc_idx <= 0, count cleared.
  - Box initialised on the first handshake, not to a sentinel.
- ISSUE: issue_valid=1.
  - center_x, center_y and alloc_idx are held stable while issue_ready=0.
- On each ISSUE handshake:
  - Box merges [cx-padding, cx+padding] x [cy-padding, cy+padding].
  - count increments.
- If the handshake is the last frame position -> DONE.
  - batch_valid pulses the same cycle done rises; partial batch count allowed.
- Else if alloc_idx==NUM_ALLOC-1 -> WAIT_BATCH, with a batch_valid pulse.
- Else alloc_idx++ and the centre advances.
- batch_valid is asserted the cycle after the closing handshake.
  - Box and count hold their values until the next batch's first handshake.

Scan order (row-major):
- Bounds: bx = padding+img_w-1, by = padding+img_h-1.
- nx = cx+stride_x. If nx<=bx: cx<=nx.
- Otherwise: cx<=padding and cy<=cy+stride_y.
- Last position: cx+stride_x>bx and cy+stride_y>by.
- All sums are computed at COORD_W+1 bits, so there is no wrap at the top of the coordinate range.

Ignored inputs:
- start outside IDLE/DONE.
- batch_req outside WAIT_BATCH.
- A batch_req held high re-triggers only on WAIT_BATCH entry.

Optional Feature:
- Macro: WINDOW_COL_MAJOR_EN.
- Defined: column-major scan.
  - Y advances by stride_y first.
  - On passing by, cy resets to padding and cx advances by stride_x.
  - The last-position test is unchanged.
- Undefined: row-major scan as above.
- Box and handshake logic are identical in both builds.

Test Plan:
1. NUM_ALLOC=4, img 4x4, pad=1, strides 1, issue_ready=1, batch_req pulsed per batch.
   - Expect 16 issues, centres (1,1)..(4,4) row-major, 4 batches each with count=4.
   - Batch 0 box x 0..5, y 0..2. Last box x 0..5, y 3..5.
   - done after the 16th handshake.
2. NUM_ALLOC=4, img 5x5, pad=0, strides 2.
   - Expect centres x,y in {0,2,4}: 9 issues.
   - Batch counts 4, 4, 1; final box x 4..4, y 4..4; batch_valid and done coincide.
3. Backpressure: drop issue_ready for 3 cycles mid-batch.
   - issue_valid, centre and alloc_idx are held constant; no skipped or duplicated centre.
4. Assert rst during the second batch.
   - Next cycle: all outputs 0, state IDLE.
   - A fresh start replays from (padding, padding).
5. start with stride_x=0 -> done=1 next cycle, issue_valid never asserts. Then start with valid config -> done clears and the frame runs.
6. WINDOW_COL_MAJOR_EN defined, case 1 stimulus.
   - Centres order (1,1),(1,2),(1,3),(1,4),(2,1)...
   - Batch 0 box x 0..2, y 0..5.

Source files
------------

// File: rtl/window_issue_sequencer.sv
// Walks convolution window centres over a padded frame and issues them to allocator slots in batches.
// Optional build macro WINDOW_COL_MAJOR_EN selects a column-major scan instead of row-major.
module window_issue_sequencer #(
  parameter int NUM_ALLOC = 220,
  parameter int COORD_W   = 8,
  parameter int PAD_W     = 2,
  parameter int STRIDE_W  = 3,
  parameter int IDX_W     = (NUM_ALLOC > 1) ? $clog2(NUM_ALLOC) : 1,
  parameter int CNT_W     = $clog2(NUM_ALLOC + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [COORD_W-1:0]  img_w,
  input  logic [COORD_W-1:0]  img_h,
  input  logic [PAD_W-1:0]    padding,
  input  logic [STRIDE_W-1:0] stride_x,
  input  logic [STRIDE_W-1:0] stride_y,
  input  logic                batch_req,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [COORD_W-1:0]  center_x,
  output logic [COORD_W-1:0]  center_y,
  output logic [IDX_W-1:0]    alloc_idx,
  output logic                batch_valid,
  output logic [CNT_W-1:0]    batch_count,
  output logic [COORD_W-1:0]  box_x_min,
  output logic [COORD_W-1:0]  box_x_max,
  output logic [COORD_W-1:0]  box_y_min,
  output logic [COORD_W-1:0]  box_y_max,
  output logic                busy,
  output logic                done
);

  localparam int W1 = COORD_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, bcnt_q, bcnt_d;
  logic [COORD_W-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
  logic [COORD_W-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
  logic                 bv_q, bv_d;

  logic [PAD_W-1:0]     pad_q;
  logic [STRIDE_W-1:0]  sx_q, sy_q;
  logic [W1-1:0]        bx_q, by_q;

  logic                 start_acc, degenerate, last_pos;
  logic [W1-1:0]        nx, ny;
  logic [COORD_W-1:0]   pad_c, lo_x, hi_x, lo_y, hi_y, cx_adv, cy_adv;

  assign start_acc  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign degenerate = (img_w == '0) || (img_h == '0) || (stride_x == '0) || (stride_y == '0);

  // Configuration is captured only when a frame is accepted; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (start_acc) begin
      pad_q <= padding;
      sx_q  <= stride_x;
      sy_q  <= stride_y;
      bx_q  <= W1'(img_w) + W1'(padding) - W1'(1);
      by_q  <= W1'(img_h) + W1'(padding) - W1'(1);
    end
  end

  assign pad_c    = COORD_W'(pad_q);
  assign nx       = {1'b0, cx_q} + W1'(sx_q);
  assign ny       = {1'b0, cy_q} + W1'(sy_q);
  assign last_pos = (nx > bx_q) && (ny > by_q);
  assign lo_x     = cx_q - pad_c;
  assign hi_x     = cx_q + pad_c;
  assign lo_y     = cy_q - pad_c;
  assign hi_y     = cy_q + pad_c;

`ifdef WINDOW_COL_MAJOR_EN
  always_comb begin
    cx_adv = cx_q;
    cy_adv = cy_q;
    if (ny <= by_q) begin
      cy_adv = ny[COORD_W-1:0];
    end else begin
      cy_adv = pad_c;
      cx_adv = nx[COORD_W-1:0];
    end
  end
`else
  always_comb begin
    cx_adv = cx_q;
    cy_adv = cy_q;
    if (nx <= bx_q) begin
      cx_adv = nx[COORD_W-1:0];
    end else begin
      cx_adv = pad_c;
      cy_adv = ny[COORD_W-1:0];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    bv_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (degenerate) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cx_d    = COORD_W'(padding);
            cy_d    = COORD_W'(padding);
          end
        end
      end
      S_WAIT: begin
        if (batch_req) begin
          state_d = S_ISSUE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        if (issue_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          // The first handshake of a batch seeds the box; later ones widen it.
          if (cnt_q == '0) begin
            xmin_d = lo_x;
            xmax_d = hi_x;
            ymin_d = lo_y;
            ymax_d = hi_y;
          end else begin
            if (lo_x < xmin_q) xmin_d = lo_x;
            if (hi_x > xmax_q) xmax_d = hi_x;
            if (lo_y < ymin_q) ymin_d = lo_y;
            if (hi_y > ymax_q) ymax_d = hi_y;
          end
          if (last_pos) begin
            state_d = S_DONE;
            bv_d    = 1'b1;
            bcnt_d  = cnt_q + CNT_W'(1);
          end else begin
            cx_d = cx_adv;
            cy_d = cy_adv;
            if (idx_q == IDX_W'(NUM_ALLOC - 1)) begin
              state_d = S_WAIT;
              bv_d    = 1'b1;
              bcnt_d  = cnt_q + CNT_W'(1);
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      bv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      bv_q    <= bv_d;
    end
  end

  assign issue_valid = (state_q == S_ISSUE);
  assign busy        = (state_q == S_WAIT) || (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);
  assign center_x    = cx_q;
  assign center_y    = cy_q;
  assign alloc_idx   = idx_q;
  assign batch_valid = bv_q;
  assign batch_count = bcnt_q;
  assign box_x_min   = xmin_q;
  assign box_x_max   = xmax_q;
  assign box_y_min   = ymin_q;
  assign box_y_max   = ymax_q;

endmodule
